// File: rtl/receiver_if.sv
// Signal bundle between the serial receiver and its surroundings:
// bit-rate ticks, line, configuration and FIFO side.
interface receiver_if;
    logic       brgen;
    logic       enable;
    logic [1:0] size;
    logic [1:0] parity;
    logic       stop2;
    logic       in;
    logic       full;
    logic [7:0] data;
    logic       wr_request;
    logic       parity_err;
    logic       frame_err;
    logic       break_err;
    logic       overrun;
    logic       busy;

    modport master (
        output brgen, enable, size, parity, stop2, in, full,
        input  data, wr_request, parity_err, frame_err, break_err, overrun, busy
    );

    modport slave (
        input  brgen, enable, size, parity, stop2, in, full,
        output data, wr_request, parity_err, frame_err, break_err, overrun, busy
    );
endinterface

// File: rtl/receiver.sv
// UART-style receiver: oversampled start/data/parity/stop de-framing with
// parity, framing, break and overrun detection feeding a receive FIFO.
module receiver #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       reset,
    receiver_if.slave bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_T = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [TW-1:0]          tick;
    logic [2:0]             bitcnt;
    logic [1:0]             cfg_size;
    logic [1:0]             cfg_parity;
    logic                   cfg_stop2;
    logic [7:0]             shift;
    logic                   any_one;
    logic                   frame_bad;
    logic                   par_bad;
    logic                   armed;
    logic [7:0]             data_q;
    logic                   perr_q, ferr_q, berr_q;
    logic                   bit_tick;
    logic [2:0]             last_bit;
    logic                   par_en;
    logic                   done_load;

    assign rxs      = sync[SYNC_STAGES-1];
    assign last_bit = 3'd4 + {1'b0, cfg_size};
    assign par_en   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    // START samples half a bit in; every later sample is a full bit after the previous one
    assign bit_tick = bus.brgen && (tick == ((state == START) ? HALF_T : FULL_T));
    assign done_load = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync[0] <= bus.in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.wr_request = 1'b0;
        bus.overrun    = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE:   if (bus.brgen && !rxs && armed) state_nxt = START;
            START:  if (bit_tick) state_nxt = rxs ? IDLE : DATA;
            DATA:   if (bit_tick && (bitcnt == last_bit)) state_nxt = par_en ? PARITY : STOP1;
            PARITY: if (bit_tick) state_nxt = STOP1;
            STOP1:  if (bit_tick) state_nxt = cfg_stop2 ? STOP2 : DONE;
            STOP2:  if (bit_tick) state_nxt = DONE;
            DONE: begin
                state_nxt      = IDLE;
                bus.wr_request = bus.enable && !bus.full;
                bus.overrun    = bus.enable && bus.full;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick       <= '0;
            bitcnt     <= '0;
            cfg_size   <= '0;
            cfg_parity <= '0;
            cfg_stop2  <= 1'b0;
            shift      <= '0;
            any_one    <= 1'b0;
            frame_bad  <= 1'b0;
            par_bad    <= 1'b0;
            armed      <= 1'b1;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            if ((state_nxt != state) || bit_tick) begin
                tick <= '0;
            end else if (bus.brgen && (state != IDLE)) begin
                tick <= tick + 1'b1;
            end

            if (state == IDLE) begin
                cfg_size   <= bus.size;
                cfg_parity <= bus.parity;
                cfg_stop2  <= bus.stop2;
            end

            if (bit_tick) begin
                case (state)
                    START: begin
                        shift     <= '0;
                        bitcnt    <= '0;
                        any_one   <= 1'b0;
                        frame_bad <= 1'b0;
                        par_bad   <= 1'b0;
                    end
                    DATA: begin
                        shift[bitcnt] <= rxs;
                        bitcnt        <= bitcnt + 3'd1;
                        any_one       <= any_one | rxs;
                    end
                    PARITY: begin
                        par_bad <= ((^shift) ^ rxs) != (cfg_parity == 2'b10);
                        any_one <= any_one | rxs;
                    end
                    STOP1, STOP2: begin
                        frame_bad <= frame_bad | !rxs;
                        any_one   <= any_one | rxs;
                    end
                    default: ;
                endcase
            end

            // The final stop sample is folded in here since its register update lands with DONE
            if (done_load) begin
                data_q <= shift;
                perr_q <= par_bad;
                ferr_q <= frame_bad | !rxs;
                berr_q <= !(any_one | rxs);
            end

            // After a break the line must be seen high before another start is accepted
            if (rxs) begin
                armed <= 1'b1;
            end else if (done_load && !any_one) begin
                armed <= 1'b0;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.break_err  = berr_q;
endmodule
